// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box scanner slice.
package bbox_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } scan_state_t;

  localparam int unsigned COORD_W_DEFAULT = 10;
  localparam int unsigned STEP_MIN        = 1;
  localparam int unsigned STEP_MAX        = 8;

endpackage

// File: rtl/bounding_box_scanner_if.sv
// Control + pixel_cache handshake bundle for bounding_box_scanner.
interface bounding_box_scanner_if
  import bbox_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT
) ();

  logic [COORD_W-1:0]   search_x0;
  logic [COORD_W-1:0]   search_x1;
  logic [COORD_W-1:0]   search_y0;
  logic [COORD_W-1:0]   search_y1;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 found;
  logic [COORD_W-1:0]   bounding_x0;
  logic [COORD_W-1:0]   bounding_x1;
  logic [COORD_W-1:0]   bounding_y0;
  logic [COORD_W-1:0]   bounding_y1;
  logic [2*COORD_W-1:0] pixel_count;
  logic [COORD_W-1:0]   x;
  logic [COORD_W-1:0]   y;
  logic                 request;
  logic                 pixel;
  logic                 ready;

  // Scanner side
  modport slave (
    input  search_x0, search_x1, search_y0, search_y1, start, pixel, ready,
    output busy, done, found, bounding_x0, bounding_x1, bounding_y0,
           bounding_y1, pixel_count, x, y, request
  );

  // Control FSM / pixel_cache side
  modport master (
    output search_x0, search_x1, search_y0, search_y1, start, pixel, ready,
    input  busy, done, found, bounding_x0, bounding_x1, bounding_y0,
           bounding_y1, pixel_count, x, y, request
  );

endinterface

// File: rtl/raster_stepper.sv
// Holds the latched search rectangle and the current raster address; advances
// by STEP per consumed pixel and flags the final sample of the rectangle.
module raster_stepper #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_c_o
);

  localparam int unsigned XW = COORD_W + 1;

  logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
  logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
  logic [XW-1:0]      x_next_w, y_next_w;
  logic               x_wrap_c, y_wrap_c;

  // One extra bit keeps x+STEP from wrapping past the top of the coordinate space
  always_comb begin
    x_next_w = {1'b0, x_q} + XW'(STEP);
    y_next_w = {1'b0, y_q} + XW'(STEP);
    x_wrap_c = x_next_w > {1'b0, x1_q};
    y_wrap_c = y_next_w > {1'b0, y1_q};
    x_d      = x_q;
    y_d      = y_q;
    if (step_i) begin
      if (x_wrap_c) begin
        x_d = x0_q;
        y_d = y_next_w[COORD_W-1:0];
      end else begin
        x_d = x_next_w[COORD_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else if (load_i) begin
      x0_q <= x0_i;
      x1_q <= x1_i;
      y0_q <= y0_i;
      y1_q <= y1_i;
      x_q  <= x0_i;
      y_q  <= y0_i;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign last_c_o = x_wrap_c & y_wrap_c;

endmodule

// File: rtl/bounding_box_scanner.sv
// Raster-scans a search rectangle through pixel_cache and reports the tight
// bounding box, count and found flag of the set sampled pixels.
module bounding_box_scanner
  import bbox_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT,
  parameter int unsigned STEP    = 1
) (
  input logic                   clk,
  input logic                   reset,
  bounding_box_scanner_if.slave bus
);

  localparam int unsigned CNT_W = 2 * COORD_W;

  if (STEP < STEP_MIN || STEP > STEP_MAX) begin : g_step_range
    $error("bounding_box_scanner: STEP must lie in 1..8");
  end

  scan_state_t        state_q;
  logic               busy_q, done_q, request_q, found_q;
  logic [COORD_W-1:0] bx0_q, bx1_q, by0_q, by1_q;
  logic [CNT_W-1:0]   count_q;

  logic               acc_found_q, acc_found_d;
  logic [COORD_W-1:0] acc_bx0_q, acc_bx1_q, acc_by0_q, acc_by1_q;
  logic [COORD_W-1:0] acc_bx0_d, acc_bx1_d, acc_by0_d, acc_by1_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

  logic [COORD_W-1:0] cur_x, cur_y;
  logic               last_c, accept_c, rect_bad_c, consume_c, hit_c;

  assign accept_c   = (state_q == IDLE) & bus.start;
  assign rect_bad_c = (bus.search_x0 > bus.search_x1) | (bus.search_y0 > bus.search_y1);
  assign consume_c  = request_q & bus.ready;
  assign hit_c      = consume_c & bus.pixel;

  raster_stepper #(
    .COORD_W (COORD_W),
    .STEP    (STEP)
  ) u_stepper (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept_c),
    .step_i   (consume_c),
    .x0_i     (bus.search_x0),
    .x1_i     (bus.search_x1),
    .y0_i     (bus.search_y0),
    .y1_i     (bus.search_y1),
    .x_o      (cur_x),
    .y_o      (cur_y),
    .last_c_o (last_c)
  );

  // Accumulator next state; the first hit seeds all four bounds
  always_comb begin
    acc_found_d = acc_found_q;
    acc_bx0_d   = acc_bx0_q;
    acc_bx1_d   = acc_bx1_q;
    acc_by0_d   = acc_by0_q;
    acc_by1_d   = acc_by1_q;
    acc_cnt_d   = acc_cnt_q;
    if (hit_c) begin
      acc_found_d = 1'b1;
      if (!acc_found_q) begin
        acc_bx0_d = cur_x;
        acc_bx1_d = cur_x;
        acc_by0_d = cur_y;
        acc_by1_d = cur_y;
      end else begin
        if (cur_x < acc_bx0_q) acc_bx0_d = cur_x;
        if (cur_x > acc_bx1_q) acc_bx1_d = cur_x;
        if (cur_y < acc_by0_q) acc_by0_d = cur_y;
        if (cur_y > acc_by1_q) acc_by1_d = cur_y;
      end
      if (~&acc_cnt_q) acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
  end

  // Results are published on the final consume; an invalid rectangle
  // publishes a cleared result from FINISH one cycle later instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      request_q   <= 1'b0;
      found_q     <= 1'b0;
      bx0_q       <= '0;
      bx1_q       <= '0;
      by0_q       <= '0;
      by1_q       <= '0;
      count_q     <= '0;
      acc_found_q <= 1'b0;
      acc_bx0_q   <= '0;
      acc_bx1_q   <= '0;
      acc_by0_q   <= '0;
      acc_by1_q   <= '0;
      acc_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q      <= 1'b1;
            acc_found_q <= 1'b0;
            acc_bx0_q   <= '0;
            acc_bx1_q   <= '0;
            acc_by0_q   <= '0;
            acc_by1_q   <= '0;
            acc_cnt_q   <= '0;
            if (rect_bad_c) begin
              state_q <= FINISH;
            end else begin
              state_q   <= SCAN;
              request_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          acc_found_q <= acc_found_d;
          acc_bx0_q   <= acc_bx0_d;
          acc_bx1_q   <= acc_bx1_d;
          acc_by0_q   <= acc_by0_d;
          acc_by1_q   <= acc_by1_d;
          acc_cnt_q   <= acc_cnt_d;
          if (consume_c && last_c) begin
            state_q   <= FINISH;
            request_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            found_q   <= acc_found_d;
            bx0_q     <= acc_bx0_d;
            bx1_q     <= acc_bx1_d;
            by0_q     <= acc_by0_d;
            by1_q     <= acc_by1_d;
            count_q   <= acc_cnt_d;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= ~done_q;
          if (!done_q) begin
            found_q <= 1'b0;
            bx0_q   <= '0;
            bx1_q   <= '0;
            by0_q   <= '0;
            by1_q   <= '0;
            count_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.found       = found_q;
  assign bus.bounding_x0 = bx0_q;
  assign bus.bounding_x1 = bx1_q;
  assign bus.bounding_y0 = by0_q;
  assign bus.bounding_y1 = by1_q;
  assign bus.pixel_count = count_q;
  assign bus.x           = cur_x;
  assign bus.y           = cur_y;
  assign bus.request     = request_q;

endmodule

// File: tb/tb_bounding_box_scanner.sv
// Scoreboard bench for bounding_box_scanner: STEP=1 and STEP=2 instances, a
// pixel_cache model with optional random stalls, and a set-based image model.
module tb_bounding_box_scanner;
  import bbox_pkg::*;

  localparam int unsigned CW = 10;

  typedef struct {
    int     inst;
    bit     found;
    int     bx0, bx1, by0, by1;
    longint cnt;
    int     samples;
    longint exp_cyc;
    int     exp_req;
  } exp_t;

  typedef struct {
    logic   busy, done, found, request;
    int     x, y, bx0, bx1, by0, by1;
    longint cnt;
  } obs_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;
  bit     stall_en = 1'b0;
  bit     img[int];
  exp_t   sbq[$];
  int     consumed[2];
  int     reqcyc[2];
  bit     pend_stall[2];
  int     px[2], py[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bounding_box_scanner_if #(.COORD_W(CW)) bus0 ();
  bounding_box_scanner_if #(.COORD_W(CW)) bus1 ();

  bounding_box_scanner #(.COORD_W(CW), .STEP(1)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  bounding_box_scanner #(.COORD_W(CW), .STEP(2)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  function automatic void chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int key(int xx, int yy);
    return yy * 4096 + xx;
  endfunction

  function automatic longint box(int a, int b, int c, int d);
    return (longint'(a) << 30) | (longint'(b) << 20) | (longint'(c) << 10) | longint'(d);
  endfunction

  function automatic obs_t snap(int i);
    obs_t o;
    if (i == 0) begin
      o.busy = bus0.busy; o.done = bus0.done; o.found = bus0.found; o.request = bus0.request;
      o.x = int'(bus0.x); o.y = int'(bus0.y);
      o.bx0 = int'(bus0.bounding_x0); o.bx1 = int'(bus0.bounding_x1);
      o.by0 = int'(bus0.bounding_y0); o.by1 = int'(bus0.bounding_y1);
      o.cnt = longint'(bus0.pixel_count);
    end else begin
      o.busy = bus1.busy; o.done = bus1.done; o.found = bus1.found; o.request = bus1.request;
      o.x = int'(bus1.x); o.y = int'(bus1.y);
      o.bx0 = int'(bus1.bounding_x0); o.bx1 = int'(bus1.bounding_x1);
      o.by0 = int'(bus1.bounding_y0); o.by1 = int'(bus1.bounding_y1);
      o.cnt = longint'(bus1.pixel_count);
    end
    return o;
  endfunction

  function automatic longint out_sum(obs_t o);
    return longint'(o.busy) + longint'(o.done) + longint'(o.found) + longint'(o.request)
         + longint'(o.x) + longint'(o.y) + longint'(o.bx0) + longint'(o.bx1)
         + longint'(o.by0) + longint'(o.by1) + o.cnt;
  endfunction

  // Reference: enumerate the sampled grid and reduce over the set pixels
  function automatic exp_t model(int i, int x0, int x1, int y0, int y1, bit stalls, longint c0);
    exp_t e;
    int   s = (i == 0) ? 1 : 2;
    e.inst = i; e.found = 1'b0; e.cnt = 0; e.samples = 0;
    e.bx0 = 0; e.bx1 = 0; e.by0 = 0; e.by1 = 0;
    for (int yy = y0; yy <= y1; yy += s) begin
      for (int xx = x0; xx <= x1; xx += s) begin
        e.samples++;
        if (img.exists(key(xx, yy))) begin
          if (!e.found) begin
            e.bx0 = xx; e.bx1 = xx; e.by0 = yy; e.by1 = yy;
          end else begin
            if (xx < e.bx0) e.bx0 = xx;
            if (xx > e.bx1) e.bx1 = xx;
            if (yy < e.by0) e.by0 = yy;
            if (yy > e.by1) e.by1 = yy;
          end
          e.found = 1'b1;
          e.cnt++;
        end
      end
    end
    if (x0 > x1 || y0 > y1) e.exp_cyc = c0 + 1;
    else                    e.exp_cyc = stalls ? -1 : c0 + e.samples;
    e.exp_req = stalls ? -1 : e.samples;
    return e;
  endfunction

  task automatic set_rect(int i, int x0, int x1, int y0, int y1);
    if (i == 0) begin
      bus0.search_x0 = CW'(x0); bus0.search_x1 = CW'(x1);
      bus0.search_y0 = CW'(y0); bus0.search_y1 = CW'(y1);
    end else begin
      bus1.search_x0 = CW'(x0); bus1.search_x1 = CW'(x1);
      bus1.search_y0 = CW'(y0); bus1.search_y1 = CW'(y1);
    end
  endtask

  task automatic set_start(int i, logic v);
    if (i == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  task automatic wait_done(int i, bit noise);
    int n = 0;
    while (sbq.size() != 0 && n < 5000) begin
      if (noise) begin
        set_rect(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023));
        set_start(i, $urandom_range(0, 4) == 0);
      end
      @(negedge clk);
      n++;
    end
    set_start(i, 1'b0);
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: inst %0d still waiting for done after %0d cycles", i, n);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_scan(int i, int x0, int x1, int y0, int y1, bit stalls, bit noise);
    longint c0;
    stall_en = stalls;
    set_rect(i, x0, x1, y0, y1);
    set_start(i, 1'b1);
    @(negedge clk);
    c0 = cyc;
    set_start(i, 1'b0);
    sbq.push_back(model(i, x0, x1, y0, y1, stalls, c0));
    wait_done(i, noise);
  endtask

  task automatic fill_random(int x0, int x1, int y0, int y1);
    img.delete();
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        if ($urandom_range(0, 2) == 0) img[key(xx, yy)] = 1'b1;
  endtask

  // Monitor + pixel_cache model, sampled on the falling edge
  initial begin
    exp_t e;
    obs_t o;
    logic r, p;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        o = snap(i);
        if (reset) begin
          consumed[i] = 0; reqcyc[i] = 0; pend_stall[i] = 1'b0;
          if (i == 0) begin bus0.ready = 1'b0; bus0.pixel = 1'b0; end
          else        begin bus1.ready = 1'b0; bus1.pixel = 1'b0; end
          continue;
        end
        if (o.done) begin
          if (sbq.size() == 0 || sbq[0].inst != i) begin
            total++; bad++;
            $display("FAIL unexpected_done: inst %0d raised done with no scan pending", i);
          end else begin
            e = sbq.pop_front();
            chk("found", longint'(o.found), longint'(e.found));
            chk("box", box(o.bx0, o.bx1, o.by0, o.by1), box(e.bx0, e.bx1, e.by0, e.by1));
            chk("count", o.cnt, e.cnt);
            chk("pixels_consumed", longint'(consumed[i]), longint'(e.samples));
            chk("busy_at_done", longint'(o.busy), 0);
            if (e.exp_cyc >= 0) chk("done_latency", cyc, e.exp_cyc);
            if (e.exp_req >= 0) chk("request_cycles", longint'(reqcyc[i]), longint'(e.exp_req));
          end
          consumed[i] = 0; reqcyc[i] = 0;
        end
        if (pend_stall[i]) begin
          chk("stall_hold_x", longint'(o.x), longint'(px[i]));
          chk("stall_hold_y", longint'(o.y), longint'(py[i]));
        end
        r = stall_en ? logic'($urandom_range(0, 2) != 0) : 1'b1;
        p = r ? logic'(img.exists(key(o.x, o.y))) : logic'($urandom_range(0, 1));
        if (i == 0) begin bus0.ready = r; bus0.pixel = p; end
        else        begin bus1.ready = r; bus1.pixel = p; end
        if (o.request) begin
          reqcyc[i]++;
          if (r) consumed[i]++;
        end
        pend_stall[i] = o.request && !r;
        px[i] = o.x;
        py[i] = o.y;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, y0;
    set_rect(0, 0, 0, 0, 0); set_rect(1, 0, 0, 0, 0);
    set_start(0, 1'b0); set_start(1, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_0", out_sum(snap(0)), 0);
    chk("reset_outputs_1", out_sum(snap(1)), 0);
    reset = 1'b0;
    @(negedge clk);

    img.delete();
    img[key(2, 3)] = 1'b1; img[key(5, 1)] = 1'b1; img[key(4, 6)] = 1'b1;
    run_scan(0, 0, 7, 0, 7, 1'b0, 1'b0);

    img.delete();
    run_scan(0, 0, 7, 0, 7, 1'b0, 1'b0);

    img.delete();
    for (int yy = 1020; yy <= 1023; yy++)
      for (int xx = 1020; xx <= 1023; xx++) img[key(xx, yy)] = 1'b1;
    run_scan(0, 1020, 1023, 1020, 1023, 1'b0, 1'b0);

    img.delete();
    img[key(2, 2)] = 1'b1; img[key(3, 3)] = 1'b1;
    run_scan(1, 1, 6, 1, 6, 1'b0, 1'b0);

    fill_random(1016, 1023, 1016, 1023);
    img[key(4, 4)] = 1'b1;
    run_scan(1, 4, 4, 4, 5, 1'b0, 1'b0);
    run_scan(1, 1019, 1023, 1019, 1023, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin
        x0 = $urandom_range(0, 1011);
        y0 = $urandom_range(0, 1011);
        fill_random(x0, x0 + 11, y0, y0 + 11);
        begin
          int x1 = x0 + $urandom_range(0, 11);
          int y1 = y0 + $urandom_range(0, 11);
          run_scan(i, x0, x1, y0, y1, 1'b0, 1'b0);
          run_scan(i, x0, x1, y0, y1, 1'b1, 1'b1);
        end
      end
    end

    run_scan(0, 5, 2, 0, 3, 1'b0, 1'b0);
    run_scan(1, 0, 3, 9, 4, 1'b0, 1'b0);

    fill_random(0, 15, 0, 15);
    stall_en = 1'b0;
    set_rect(0, 0, 15, 0, 15);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_scan", out_sum(snap(0)), 0);
    reset = 1'b0;
    @(negedge clk);
    run_scan(0, 0, 15, 0, 15, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bounding_box_scanner.md
# bounding_box_scanner

Parametrised successor to the team's bounding-box search blocks. Raster-scans a caller-supplied search rectangle through the pixel_cache request/ready handshake, with a programmable subsampling stride. Reports the tight bounding box of all set pixels, their count, and a found flag. Sits between the blob-detection control FSM and pixel_cache, and replaces the separate edge-search and area passes with a single scan.

## Interface
Parameters:
- COORD_W, 10: coordinate width in bits.
- STEP, 1: scan stride in x and y (1..8). Every STEP-th column/row is sampled, starting at search_x0/search_y0.

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- search_x0, search_x1, search_y0, search_y1  in  COORD_W each  inclusive search rectangle. Sampled on an accepted start.
- start  in  1  begin scan. Accepted only in IDLE.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- found  out  1  at least one sampled pixel was set.
- bounding_x0, bounding_x1, bounding_y0, bounding_y1  out  COORD_W each  inclusive box of set sampled pixels. All zero when found=0.
- pixel_count  out  2*COORD_W  number of set sampled pixels.
- x, y  out  COORD_W each  pixel address to pixel_cache.
- request  out  1  pixel wanted at x,y.
- pixel  in  1  pixel value. Valid only when ready=1.
- ready  in  1  pixel_cache has returned the pixel for the current x,y.

## Operation
- FSM states: IDLE, SCAN, FINISH.
- IDLE:
  - On start, latch the rectangle.
  - If x0>x1 or y0>y1, go to FINISH with found=0 and count=0.
  - Otherwise set x=x0, y=y0, clear the accumulators, and go to SCAN.
- SCAN:
  - request=1 continuously. x,y are held stable until a cycle with ready=1.
  - In a ready cycle, if pixel=1:
    - min/max update: bx0=min(bx0,x), bx1=max(bx1,x), by0=min(by0,y), by1=max(by1,y).
    - count+=1.
    - The first set pixel initialises all four bounds to (x,y).
  - Advance (next cycle):
    - If x+STEP>x1 (evaluated in COORD_W+1 bits), x=x0 and y+=STEP.
    - Otherwise x+=STEP.
  - If the consumed pixel was the last one (x+STEP>x1 and y+STEP>y1), go to FINISH instead.
- FINISH:
  - Register the outputs, pulse done, return to IDLE.
  - Results hold until the next accepted start.
- Accumulators:
  - Internal bounds accumulate separately and are copied to the outputs only in FINISH, so outputs never show partial scans.
  - count saturates at all-ones.
- Stride: a rectangle narrower than STEP still samples its first column/row.
- start while busy: ignored, no effect.
- reset: in any state, returns to IDLE on the next edge and clears every output. An outstanding request is abandoned; a late ready is ignored in IDLE.

## Timing
- Reset values: busy=0, done=0, found=0, request=0, x=y=0, all bounding outputs=0, pixel_count=0.
- start accepted at edge N: busy=1 and request=1 from cycle N+1, x=x0, y=y0.
- Per pixel: one ready cycle consumes it, and the new x,y appear the following cycle. request is not dropped between pixels. With ready always high, throughput is one pixel per clock.
- Latency: done asserts one cycle after the final ready, with outputs valid in that same cycle. busy falls with done.
- Invalid rectangle: done at cycle N+2, and request is never asserted.
- ready while request=0: ignored.

## Structure
- Package bbox_pkg:
  - scan_state_t enum (IDLE, SCAN, FINISH).
  - Default COORD_W constant.
  - STEP legality range constants, checked by an elaboration assertion.
- Sub-module raster_stepper:
  - Holds x,y and the x0/x1/y0/y1 latches.
  - Advances on a step input and produces the last flag using the widened comparison.
- Top-level bounding_box_scanner contains the FSM, the min/max/count accumulators and the output registers.

## Test plan
- Rectangle (0,0)-(7,7), STEP=1, pixels set at (2,3),(5,1),(4,6), ready always high -> 64 requests, done at cycle 65, box (2,1)-(5,6), count=3, found=1.
- Same rectangle with all pixels clear -> found=0, box all zero, count=0, done after 64 pixels.
- STEP=2, rectangle (1,1)-(6,6), only (2,2) and (3,3) set -> samples x,y∈{1,3,5}, box (3,3)-(3,3), count=1, 9 requests.
- Rectangle (1020,1020)-(1023,1023) with COORD_W=10, all set -> no wrap overflow, box (1020,1020)-(1023,1023), count=16, exactly 16 requests.
- Random ready stalls plus start pulses mid-scan -> x,y stable across stalls, extra starts ignored, results identical to the no-stall run.
- search_x0=5 > search_x1=2 -> done at N+2, request never high. Separately, reset mid-scan -> all outputs zero next cycle, and a fresh start rescans cleanly.
